// File: rtl/trackball_pkg.sv
// Shared types and timing helpers for the trackball clock/direction pulse generator.
package trackball_pkg;

  typedef enum logic [1:0] {AX_IDLE, AX_SETUP, AX_HIGH, AX_LOW} ax_state_e;
  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} top_state_e;

  // High phase takes the floor half of the period, low phase the remainder.
  function automatic int unsigned high_cyc(input int unsigned period);
    return period / 2;
  endfunction

  function automatic int unsigned low_cyc(input int unsigned period);
    return period - (period / 2);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/quad_axis.sv
// One axis: direction setup delay, then a burst of clock pulses of the latched magnitude.
module quad_axis
  import trackball_pkg::*;
#(
  parameter int unsigned STEP_PERIOD = 1000,
  parameter int unsigned DIR_SETUP   = 100,
  parameter int unsigned DELTA_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [DELTA_W-1:0] mag_i,
  input  logic               neg_i,
  output logic               clk_o,
  output logic               dir_o,
  output logic               finish_o
);

  localparam int unsigned HIGH_CYC = high_cyc(STEP_PERIOD);
  localparam int unsigned LOW_CYC  = low_cyc(STEP_PERIOD);
  localparam int unsigned CNT_W    = cnt_width(DIR_SETUP, HIGH_CYC, LOW_CYC);

  ax_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DELTA_W-1:0] rem_q;
  logic               clk_q;
  logic               dir_q;

  // Combinational: high during the final cycle of the last low phase.
  assign finish_o = (state_q == AX_LOW) && (cnt_q == CNT_W'(LOW_CYC - 1)) &&
                    (rem_q == DELTA_W'(1));
  assign clk_o    = clk_q;
  assign dir_o    = dir_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= AX_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      clk_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      case (state_q)
        AX_IDLE: begin
          // A zero magnitude never leaves idle, so dir keeps its old value.
          if (start_i && (mag_i != '0)) begin
            dir_q   <= ~neg_i;
            rem_q   <= mag_i;
            cnt_q   <= '0;
            state_q <= AX_SETUP;
          end
        end
        AX_SETUP: begin
          if (cnt_q == CNT_W'(DIR_SETUP - 1)) begin
            cnt_q   <= '0;
            clk_q   <= 1'b1;
            state_q <= AX_HIGH;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        AX_HIGH: begin
          if (cnt_q == CNT_W'(HIGH_CYC - 1)) begin
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            state_q <= AX_LOW;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        AX_LOW: begin
          if (cnt_q == CNT_W'(LOW_CYC - 1)) begin
            cnt_q <= '0;
            if (rem_q == DELTA_W'(1)) begin
              rem_q   <= '0;
              state_q <= AX_IDLE;
            end else begin
              rem_q   <= rem_q - DELTA_W'(1);
              clk_q   <= 1'b1;
              state_q <= AX_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/trackball_quad_gen.sv
// Trackball emulator: turns signed X/Y step requests into LETA clock/direction pulse bursts.
module trackball_quad_gen
  import trackball_pkg::*;
#(
  parameter int unsigned STEP_PERIOD = 1000,
  parameter int unsigned DIR_SETUP   = 100,
  parameter int unsigned DELTA_W     = 8
) (
  input  logic               GCLK,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DELTA_W-1:0] dx,
  input  logic [DELTA_W-1:0] dy,
  output logic               busy,
  output logic               done,
  output logic               clk_x,
  output logic               dir_x,
  output logic               clk_y,
  output logic               dir_y
);

  top_state_e         state_q;
  logic               req_ready_q;
  logic               busy_q;
  logic               done_q;
  logic               fin_x_q;
  logic               fin_y_q;
  logic               accept;
  logic               zero_x;
  logic               zero_y;
  logic [DELTA_W-1:0] mag_x;
  logic [DELTA_W-1:0] mag_y;
  logic               ax_fin_x;
  logic               ax_fin_y;

  assign accept = (state_q == T_IDLE) && req_ready_q && req_valid;
  assign zero_x = (dx == '0);
  assign zero_y = (dy == '0);
  // Unsigned magnitude; the most negative code maps to 2^(DELTA_W-1).
  assign mag_x  = dx[DELTA_W-1] ? DELTA_W'(-dx) : dx;
  assign mag_y  = dy[DELTA_W-1] ? DELTA_W'(-dy) : dy;

  quad_axis #(
    .STEP_PERIOD(STEP_PERIOD),
    .DIR_SETUP  (DIR_SETUP),
    .DELTA_W    (DELTA_W)
  ) u_axis_x (
    .clk_i   (GCLK),
    .rst_i   (reset),
    .start_i (accept),
    .mag_i   (mag_x),
    .neg_i   (dx[DELTA_W-1]),
    .clk_o   (clk_x),
    .dir_o   (dir_x),
    .finish_o(ax_fin_x)
  );

  quad_axis #(
    .STEP_PERIOD(STEP_PERIOD),
    .DIR_SETUP  (DIR_SETUP),
    .DELTA_W    (DELTA_W)
  ) u_axis_y (
    .clk_i   (GCLK),
    .rst_i   (reset),
    .start_i (accept),
    .mag_i   (mag_y),
    .neg_i   (dy[DELTA_W-1]),
    .clk_o   (clk_y),
    .dir_o   (dir_y),
    .finish_o(ax_fin_y)
  );

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Finish flags remember an axis that ended earlier; a zero axis is finished at accept.
  always_ff @(posedge GCLK) begin
    if (reset) begin
      state_q     <= T_IDLE;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fin_x_q     <= 1'b0;
      fin_y_q     <= 1'b0;
    end else begin
      case (state_q)
        T_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            fin_x_q     <= zero_x;
            fin_y_q     <= zero_y;
            if (zero_x && zero_y) begin
              done_q  <= 1'b1;
              state_q <= T_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= T_RUN;
            end
          end
        end
        T_RUN: begin
          fin_x_q <= fin_x_q | ax_fin_x;
          fin_y_q <= fin_y_q | ax_fin_y;
          if ((fin_x_q | ax_fin_x) && (fin_y_q | ax_fin_y)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= T_DONE;
          end
        end
        T_DONE: begin
          done_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= T_IDLE;
        end
        default: state_q <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trackball_quad_gen.sv
// Bench for trackball_quad_gen: burst expectations queued at request time, checked at done.
module tb_trackball_quad_gen;

  localparam int unsigned SP = 10;
  localparam int unsigned DS = 3;
  localparam int unsigned DW = 8;
  localparam int          HI = SP / 2;
  localparam int          BUDGET = 3000;

  logic          GCLK = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] dx;
  logic [DW-1:0] dy;
  logic          busy;
  logic          done;
  logic          clk_x;
  logic          dir_x;
  logic          clk_y;
  logic          dir_y;

  trackball_quad_gen #(
    .STEP_PERIOD(SP),
    .DIR_SETUP  (DS),
    .DELTA_W    (DW)
  ) dut (
    .GCLK     (GCLK),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .dx       (dx),
    .dy       (dy),
    .busy     (busy),
    .done     (done),
    .clk_x    (clk_x),
    .dir_x    (dir_x),
    .clk_y    (clk_y),
    .dir_y    (dir_y)
  );

  always #5 GCLK = ~GCLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge GCLK) cyc <= cyc + 1;

  typedef struct {
    int ex;
    int ey;
    int dly;
  } exp_t;
  exp_t sb_q[$];

  // Burst context written by the stimulus side, read by the monitor.
  bit   armed = 1'b0;
  int   t_acc = 0;
  int   m_nx = 0;
  int   m_ny = 0;
  logic hold_x = 1'b0;
  logic hold_y = 1'b0;

  // Monotonic monitor counters; tasks compare deltas against a baseline.
  int   rises_x = 0, rises_y = 0, leta_x = 0, leta_y = 0;
  int   wave_err_x = 0, wave_err_y = 0, dir_err_x = 0, dir_err_y = 0;
  int   done_cnt = 0;
  logic prev_x = 1'b0, prev_y = 1'b0;
  int   mon_off;
  logic mon_dx, mon_dy;

  int b_rx, b_ry, b_lx, b_ly, b_wx, b_wy, b_dx, b_dy, b_done;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic exp_clk(input int off, input int n);
    int o0;
    o0 = off - 1 - int'(DS);
    return (n > 0) && (o0 >= 0) && (o0 < n * int'(SP)) && ((o0 % int'(SP)) < HI);
  endfunction

  // LETA read-path model plus per-cycle waveform and direction checks against the burst plan.
  always @(negedge GCLK) begin
    if (clk_x === 1'b1 && prev_x === 1'b0) begin
      rises_x = rises_x + 1;
      leta_x  = leta_x + (dir_x ? 1 : -1);
    end
    if (clk_y === 1'b1 && prev_y === 1'b0) begin
      rises_y = rises_y + 1;
      leta_y  = leta_y + (dir_y ? 1 : -1);
    end
    prev_x = clk_x;
    prev_y = clk_y;
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (armed) begin
      mon_off = cyc - t_acc;
      if (clk_x !== exp_clk(mon_off, iabs(m_nx))) wave_err_x = wave_err_x + 1;
      if (clk_y !== exp_clk(mon_off, iabs(m_ny))) wave_err_y = wave_err_y + 1;
      mon_dx = (mon_off >= 1 && m_nx != 0) ? (m_nx > 0) : hold_x;
      mon_dy = (mon_off >= 1 && m_ny != 0) ? (m_ny > 0) : hold_y;
      if (dir_x !== mon_dx) dir_err_x = dir_err_x + 1;
      if (dir_y !== mon_dy) dir_err_y = dir_err_y + 1;
    end
  end

  task automatic tick;
    @(posedge GCLK);
    #1;
  endtask

  task automatic issue(input int ix, input int iy);
    int   n;
    exp_t e;
    n = 0;
    while (req_ready !== 1'b1 && n < BUDGET) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_wait_ready: req_ready=%b after %0d cycles, need 1", req_ready, n);
    end
    dx        = DW'(ix);
    dy        = DW'(iy);
    req_valid = 1'b1;
    t_acc  = cyc;
    m_nx   = ix;
    m_ny   = iy;
    hold_x = dir_x;
    hold_y = dir_y;
    b_rx = rises_x;  b_ry = rises_y;  b_lx = leta_x;  b_ly = leta_y;
    b_wx = wave_err_x; b_wy = wave_err_y; b_dx = dir_err_x; b_dy = dir_err_y;
    b_done = done_cnt;
    armed  = 1'b1;
    e.ex  = ix;
    e.ey  = iy;
    e.dly = (ix == 0 && iy == 0) ? 1 :
            1 + int'(DS) + ((iabs(ix) > iabs(iy)) ? iabs(ix) : iabs(iy)) * int'(SP);
    sb_q.push_back(e);
    tick();
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_accept: req_ready=%b need 0", req_ready);
    end
    checks++;
    if (busy !== ((ix == 0 && iy == 0) ? 1'b0 : 1'b1)) begin
      errors++;
      $display("FAIL busy_after_accept: busy=%b dx=%0d dy=%0d", busy, ix, iy);
    end
  endtask

  task automatic finish_burst(input bit noise);
    exp_t e;
    int   n;
    int   off;
    bit   seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < BUDGET) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        off = cyc - t_acc;
        if (noise && off >= 2 && off <= 20) begin
          req_valid = 1'b1;
          dx = DW'(7);
          dy = '0;
        end else begin
          req_valid = 1'b0;
        end
        tick();
        n++;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", BUDGET);
      armed = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    off = cyc - t_acc;
    e = sb_q.pop_front();
    if (off != e.dly) begin
      errors++;
      $display("FAIL done_latency: done at T+%0d need T+%0d", off, e.dly);
    end
    tick();
    armed = 1'b0;
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_done: done=%b req_ready=%b busy=%b need 0/1/0", done, req_ready, busy);
    end
    checks++;
    if (rises_x - b_rx != iabs(e.ex)) begin
      errors++;
      $display("FAIL pulses_x: got %0d need %0d", rises_x - b_rx, iabs(e.ex));
    end
    checks++;
    if (rises_y - b_ry != iabs(e.ey)) begin
      errors++;
      $display("FAIL pulses_y: got %0d need %0d", rises_y - b_ry, iabs(e.ey));
    end
    checks++;
    if (leta_x - b_lx != e.ex || leta_y - b_ly != e.ey) begin
      errors++;
      $display("FAIL leta_count: x=%0d y=%0d need x=%0d y=%0d",
               leta_x - b_lx, leta_y - b_ly, e.ex, e.ey);
    end
    checks++;
    if (wave_err_x != b_wx || wave_err_y != b_wy) begin
      errors++;
      $display("FAIL clk_waveform: bad cycles x=%0d y=%0d need 0",
               wave_err_x - b_wx, wave_err_y - b_wy);
    end
    checks++;
    if (dir_err_x != b_dx || dir_err_y != b_dy) begin
      errors++;
      $display("FAIL dir_level: bad cycles x=%0d y=%0d need 0",
               dir_err_x - b_dx, dir_err_y - b_dy);
    end
    checks++;
    if (done_cnt - b_done != 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d need 1", done_cnt - b_done);
    end
  endtask

  task automatic run_burst(input int ix, input int iy, input bit noise);
    issue(ix, iy);
    finish_burst(noise);
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = 1'b1;
    dx        = DW'(5);
    dy        = DW'(2);
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req_ready=%b busy=%b done=%b need 1/0/0", req_ready, busy, done);
    end
    checks++;
    if (clk_x !== 1'b0 || dir_x !== 1'b0 || clk_y !== 1'b0 || dir_y !== 1'b0) begin
      errors++;
      $display("FAIL reset_axes: clk_x=%b dir_x=%b clk_y=%b dir_y=%b need 0", clk_x, dir_x, clk_y, dir_y);
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || dir_x !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: busy=%b req_ready=%b dir_x=%b done=%b", busy, req_ready, dir_x, done);
    end
  endtask

  task automatic test_single;
    run_burst(3, 0, 1'b0);
  endtask

  task automatic test_min_neg;
    run_burst(-128, 0, 1'b0);
  endtask

  task automatic test_both_axes;
    run_burst(2, -5, 1'b0);
  endtask

  task automatic test_zero;
    run_burst(0, 3, 1'b0);
    run_burst(0, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_burst(2, 0, 1'b1);
    run_burst(7, 0, 1'b0);
  endtask

  task automatic test_reset_mid;
    int n;
    issue(4, 0);
    n = 0;
    while (rises_x - b_rx < 2 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (clk_x !== 1'b1) begin
      errors++;
      $display("FAIL mid_second_high: clk_x=%b need 1", clk_x);
    end
    armed = 1'b0;
    void'(sb_q.pop_front());
    reset = 1'b1;
    tick();
    checks++;
    if (clk_x !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0 || dir_x !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: clk_x=%b busy=%b req_ready=%b done=%b dir_x=%b need 0/0/1/0/0",
               clk_x, busy, req_ready, done, dir_x);
    end
    reset = 1'b0;
    tick();
    run_burst(3, -2, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    dx        = '0;
    dy        = '0;
    test_reset();
    test_single();
    test_min_neg();
    test_both_axes();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
